// File: rtl/mm_tile_scheduler.sv
// Tile sequencer for an N1 x N2 systolic array over one M x M matrix product.
// Optional macro SCHED_STALL_EN adds a stall input that freezes FEED/DRAIN.
module mm_tile_scheduler #(
    parameter int N1 = 4,
    parameter int N2 = 8,
    parameter int M  = 16,
    localparam int AW  = $clog2(M * M / N1),
    localparam int BW  = $clog2(M * M / N2),
    localparam int PW  = $clog2(M),
    localparam int SAW = (M / N1 > 1) ? $clog2(M / N1) : 1,
    localparam int SBW = (M / N2 > 1) ? $clog2(M / N2) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
`ifdef SCHED_STALL_EN
    input  logic           stall,
`endif
    output logic           busy,
    output logic           done,
    output logic           rd_en,
    output logic [AW-1:0]  rd_addr_A,
    output logic [BW-1:0]  rd_addr_B,
    output logic [PW-1:0]  pixel_cntr,
    output logic [SAW-1:0] slice_cntr_A,
    output logic [SBW-1:0] slice_cntr_B,
    output logic           acc_clr,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [SAW-1:0] out_slice_A,
    output logic [SBW-1:0] out_slice_B
);

    localparam int DW = (N1 + N2 - 1 > 1) ? $clog2(N1 + N2 - 1) : 1;
    localparam logic [PW-1:0]  P_LAST = PW'(M - 1);
    localparam logic [DW-1:0]  D_LAST = DW'(N1 + N2 - 2);
    localparam logic [SAW-1:0] A_LAST = SAW'(M / N1 - 1);
    localparam logic [SBW-1:0] B_LAST = SBW'(M / N2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        FEED,
        DRAIN,
        FLUSH,
        DONE
    } state_t;

    state_t         state, state_n;
    logic [DW-1:0]  drain, drain_n;
    logic [PW-1:0]  pixel_n;
    logic [SAW-1:0] sa_n;
    logic [SBW-1:0] sb_n;
    logic           issue;
    logic           hold;

`ifdef SCHED_STALL_EN
    assign hold = stall;
`else
    assign hold = 1'b0;
`endif

    always_comb begin
        state_n = state;
        drain_n = drain;
        pixel_n = pixel_cntr;
        sa_n    = slice_cntr_A;
        sb_n    = slice_cntr_B;
        issue   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = FEED;
                    pixel_n = '0;
                    sa_n    = '0;
                    sb_n    = '0;
                    issue   = 1'b1;
                end
            end
            FEED: begin
                if (!hold) begin
                    if (pixel_cntr == P_LAST) begin
                        state_n = DRAIN;
                        pixel_n = '0;
                        drain_n = '0;
                    end else begin
                        pixel_n = pixel_cntr + 1'b1;
                        issue   = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (!hold) begin
                    if (drain == D_LAST) state_n = FLUSH;
                    else drain_n = drain + 1'b1;
                end
            end
            FLUSH: begin
                if (out_ready) begin
                    if (slice_cntr_A == A_LAST && slice_cntr_B == B_LAST) begin
                        state_n = DONE;
                        sa_n    = '0;
                        sb_n    = '0;
                    end else begin
                        // B is the inner loop, A the outer
                        if (slice_cntr_B == B_LAST) begin
                            sb_n = '0;
                            sa_n = slice_cntr_A + 1'b1;
                        end else begin
                            sb_n = slice_cntr_B + 1'b1;
                        end
                        state_n = FEED;
                        pixel_n = '0;
                        issue   = 1'b1;
                    end
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            drain        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            rd_en        <= 1'b0;
            rd_addr_A    <= '0;
            rd_addr_B    <= '0;
            pixel_cntr   <= '0;
            slice_cntr_A <= '0;
            slice_cntr_B <= '0;
            acc_clr      <= 1'b0;
            out_valid    <= 1'b0;
            out_slice_A  <= '0;
            out_slice_B  <= '0;
        end else begin
            state        <= state_n;
            drain        <= drain_n;
            busy         <= (state_n != IDLE);
            done         <= (state_n == DONE);
            rd_en        <= issue;
            rd_addr_A    <= AW'(int'(sa_n) * M + int'(pixel_n));
            rd_addr_B    <= BW'(int'(sb_n) * M + int'(pixel_n));
            pixel_cntr   <= pixel_n;
            slice_cntr_A <= sa_n;
            slice_cntr_B <= sb_n;
            acc_clr      <= issue && (pixel_n == '0);
            out_valid    <= (state_n == FLUSH);
            out_slice_A  <= (state_n == FLUSH) ? sa_n : '0;
            out_slice_B  <= (state_n == FLUSH) ? sb_n : '0;
        end
    end

endmodule
